// File: rtl/conv_encoder_framed.sv
// Rate-1/2 framed convolutional encoder. Each frame can be followed by K-1 zero tail
// symbols, and a single output register carries downstream backpressure.
module conv_encoder_framed #(
  parameter int           K       = 3,
  parameter logic [K-1:0] G0      = 3'b111,
  parameter logic [K-1:0] G1      = 3'b101,
  parameter bit           TAIL_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_data,
  input  logic       i_last,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [1:0] o_data,
  output logic       o_last,
  output logic       o_busy
);

  localparam int SW = K - 1;
  localparam int CW = (K > 2) ? $clog2(K - 1) : 1;

  typedef enum logic {S_DATA, S_TAIL} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [1:0]    data_q, data_d;
  logic          last_q, last_d;

  logic          slot_free, accept, tail_go, u;
  logic [K-1:0]  word;

  always_comb begin
    slot_free = !valid_q || i_ready;
    o_ready   = (state_q == S_DATA) && slot_free && !i_rst;
    accept    = i_valid && o_ready;
    tail_go   = (state_q == S_TAIL) && slot_free;
    // The tail feeds zeros; the MSB of word is the current bit, the LSB the oldest.
    u         = accept && i_data;
    word      = {u, sr_q};

    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q && !i_ready;
    data_d  = data_q;
    last_d  = last_q;

    if (accept || tail_go) begin
      valid_d = 1'b1;
      data_d  = {^(word & G0), ^(word & G1)};
      sr_d    = word[K-1:1];
      last_d  = 1'b0;
    end

    if (accept && i_last) begin
      if (TAIL_EN) begin
        state_d = S_TAIL;
        cnt_d   = '0;
      end else begin
        last_d = 1'b1;
        sr_d   = '0;
      end
    end

    if (tail_go) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(K - 2)) begin
        last_d  = 1'b1;
        state_d = S_DATA;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_DATA;
      sr_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= 2'b00;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;
  assign o_busy  = (state_q == S_TAIL) || valid_q;

endmodule

// File: tb/tb_conv_encoder_framed.sv
// Scoreboard bench for conv_encoder_framed: a tail-enabled DUT driven by directed and
// random frames, plus a tail-disabled DUT on its own small directed sequence.
module tb_conv_encoder_framed;
  localparam int       K  = 3;
  localparam bit [2:0] G0 = 3'b111;
  localparam bit [2:0] G1 = 3'b101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_rst = 1'b1;
  logic       i_valid = 1'b0, i_data = 1'b0, i_last = 1'b0, i_ready = 1'b1;
  logic       o_ready0, o_valid0, o_last0, o_busy0;
  logic [1:0] o_data0;
  logic       v1 = 1'b0, d1 = 1'b0, l1 = 1'b0, r1 = 1'b1;
  logic       o_ready1, o_valid1, o_last1, o_busy1;
  logic [1:0] o_data1;

  conv_encoder_framed #(.K(K), .G0(G0), .G1(G1), .TAIL_EN(1'b1)) dut0 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready0), .i_data(i_data),
    .i_last(i_last), .o_valid(o_valid0), .i_ready(i_ready), .o_data(o_data0),
    .o_last(o_last0), .o_busy(o_busy0));

  conv_encoder_framed #(.K(K), .G0(G0), .G1(G1), .TAIL_EN(1'b0)) dut1 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(v1), .o_ready(o_ready1), .i_data(d1),
    .i_last(l1), .o_valid(o_valid1), .i_ready(r1), .o_data(o_data1),
    .o_last(o_last1), .o_busy(o_busy1));

  int checks = 0, passes = 0;
  int cyc = 0;
  int pop0 = 0, first_cyc = 0, last_cyc = 0;
  bit rnd_ready = 1'b0, ready_dir = 1'b1;
  logic [2:0] q0[$];   // {last, data}
  logic [2:0] q1[$];
  bit hist[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    i_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_dir;
  end

  // Monitors: every consumed symbol must match the head of its scoreboard queue.
  always @(negedge clk) begin
    logic [2:0] e;
    if (o_valid0 && i_ready) begin
      if (q0.size() == 0) check("dut0_unexpected_symbol", 1, 0);
      else begin
        e = q0.pop_front();
        check("dut0_symbol", {o_last0, o_data0}, e);
        if (pop0 == 0) first_cyc = cyc;
        last_cyc = cyc;
        pop0++;
      end
    end
    if (o_valid1 && r1) begin
      if (q1.size() == 0) check("dut1_unexpected_symbol", 1, 0);
      else begin
        e = q1.pop_front();
        check("dut1_symbol", {o_last1, o_data1}, e);
      end
    end
  end

  // Reference: each symbol is the generator-weighted parity over the last K frame bits.
  task automatic push_sym(input bit lst);
    bit p1, p0, b;
    int n;
    p1 = 0; p0 = 0;
    n = hist.size() - 1;
    for (int j = 0; j < K; j++) begin
      b = (n - j >= 0) ? hist[n - j] : 1'b0;
      p1 ^= G0[K-1-j] & b;
      p0 ^= G1[K-1-j] & b;
    end
    q0.push_back({lst, p1, p0});
  endtask

  task automatic model_push(input bit d, input bit l);
    hist.push_back(d);
    push_sym(1'b0);
    if (l) begin
      for (int t = 0; t < K - 1; t++) begin
        hist.push_back(1'b0);
        push_sym(t == K - 2);
      end
      hist.delete();
    end
  endtask

  task automatic send(input bit d, input bit l, input bit mdl);
    int n;
    n = 0;
    i_valid = 1'b1; i_data = d; i_last = l;
    @(negedge clk);
    while (!o_ready0 && n < 300) begin n++; @(negedge clk); end
    if (!o_ready0) check("accept_timeout", 0, 1);
    if (mdl) model_push(d, l);
    @(posedge clk); #1;
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic send1(input bit d, input bit l);
    int n;
    n = 0;
    v1 = 1'b1; d1 = d; l1 = l;
    @(negedge clk);
    while (!o_ready1 && n < 300) begin n++; @(negedge clk); end
    if (!o_ready1) check("dut1_accept_timeout", 0, 1);
    @(posedge clk); #1;
    v1 = 1'b0; l1 = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q0.size() != 0 || q1.size() != 0 || o_valid0 || o_valid1 || o_busy0) && g < 500) begin
      @(negedge clk); g++;
    end
    check("drain_pending", q0.size() + q1.size(), 0);
    check("drain_busy", o_busy0, 0);
    @(posedge clk); #1;
  endtask

  task automatic push_c(input logic [2:0] e);
    q0.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bits2[8];
    int acc, gap, g;
    bits2 = '{0, 0, 1, 0, 1, 0, 0, 1};

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_o_ready", o_ready0, 0);
    check("rst_o_valid", o_valid0, 0);
    check("rst_o_ready_notail", o_ready1, 0);
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(negedge clk);
    check("post_rst_o_ready", o_ready0, 1);
    check("post_rst_o_busy", o_busy0, 0);
    check("post_rst_o_data", o_data0, 0);
    check("post_rst_o_last", o_last0, 0);
    check("post_rst_o_valid", o_valid0, 0);
    @(posedge clk); #1;

    // Alternating frame, full throughput
    foreach (q0[i]) ;
    push_c(3'b011); push_c(3'b010); push_c(3'b000); push_c(3'b010);
    push_c(3'b000); push_c(3'b010); push_c(3'b000); push_c(3'b010);
    push_c(3'b011); push_c(3'b100);
    pop0 = 0;
    for (int i = 0; i < 8; i++) send(~i[0], i == 7, 1'b0);
    drain();
    check("t1_symbol_count", pop0, 10);
    check("t1_consecutive_cycles", last_cyc - first_cyc, 9);

    // Decoder reference frame 00101001
    push_c(3'b000); push_c(3'b000); push_c(3'b011); push_c(3'b010);
    push_c(3'b000); push_c(3'b010); push_c(3'b011); push_c(3'b011);
    push_c(3'b010); push_c(3'b111);
    for (int i = 0; i < 8; i++) send(bits2[i], i == 7, 1'b0);
    drain();

    // Backpressure after the second symbol
    push_c(3'b011); push_c(3'b010); push_c(3'b000); push_c(3'b010);
    push_c(3'b011); push_c(3'b100);
    send(1, 0, 0);
    send(0, 0, 0);
    ready_dir = 1'b0;
    i_valid = 1'b1; i_data = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_o_valid", o_valid0, 1);
      check("bp_o_data", o_data0, 2'b10);
      check("bp_o_ready", o_ready0, 0);
      @(posedge clk); #1;
    end
    ready_dir = 1'b1;
    send(1, 0, 0);
    send(0, 1, 0);
    drain();

    // Back-to-back single-bit frames with i_valid held
    push_c(3'b011); push_c(3'b010); push_c(3'b111);
    push_c(3'b011); push_c(3'b010); push_c(3'b111);
    acc = 0; gap = 0; g = 0;
    i_valid = 1'b1; i_data = 1'b1; i_last = 1'b1;
    while (acc < 2 && g < 50) begin
      @(negedge clk);
      if (o_ready0) acc++;
      else if (acc == 1) gap++;
      @(posedge clk); #1;
      g++;
    end
    i_valid = 1'b0; i_last = 1'b0;
    check("b2b_accepts", acc, 2);
    check("b2b_tail_gap", gap, 2);
    drain();

    // Reset during the first tail symbol
    push_c(3'b011);
    send(1, 1, 0);
    i_rst = 1'b1;
    @(negedge clk);
    check("rst_tail_o_ready", o_ready0, 0);
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(negedge clk);
    check("rst_tail_o_valid", o_valid0, 0);
    check("rst_tail_o_last", o_last0, 0);
    check("rst_tail_o_busy", o_busy0, 0);
    check("rst_tail_o_ready", o_ready0, 1);
    @(posedge clk); #1;
    push_c(3'b011); push_c(3'b010); push_c(3'b111);
    send(1, 1, 0);
    drain();

    // Random frames, bubbles and backpressure against the model
    rnd_ready = 1'b1;
    for (int f = 0; f < 25; f++) begin
      int len;
      len = $urandom_range(1, 9);
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send($urandom_range(0, 1), b == len - 1, 1'b1);
      end
    end
    rnd_ready = 1'b0; ready_dir = 1'b1;
    drain();

    // No-tail variant
    q1.push_back(3'b011); q1.push_back(3'b101); q1.push_back(3'b100);
    send1(1, 0);
    send1(1, 1);
    send1(0, 1);
    drain();
    check("notail_busy", o_busy1, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
